// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use hazards, handles taken-branch
// flushes and the HLT instruction, and counts inserted stalls and flushes.
//
// Handshake: this block has no valid/ready interfaces. Every control output is
// a combinational function of the current state and the present inputs, and
// it takes effect at the next rising clock edge.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ID_EX_MemRead,
   input  logic [3:0]       ID_EX_RegisterRd,
   input  logic [3:0]       IF_ID_RegisterRs,
   input  logic [3:0]       IF_ID_RegisterRt,
   input  logic             IF_ID_UsesRs,
   input  logic             IF_ID_UsesRt,
   input  logic [3:0]       IF_ID_Opcode,
   input  logic             EX_BranchTaken,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       state_dbg_o
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HALT  = 2'd2
   } state_e;

   localparam logic [3:0] OP_HLT = 4'hF;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             stall_inc, flush_inc;
   logic             load_use;
   logic             is_hlt;

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   assign load_use = ID_EX_MemRead && (ID_EX_RegisterRd != 4'd0) &&
                     ((IF_ID_UsesRs && (IF_ID_RegisterRs == ID_EX_RegisterRd)) ||
                      (IF_ID_UsesRt && (IF_ID_RegisterRt == ID_EX_RegisterRd)));
   assign is_hlt   = (IF_ID_Opcode == OP_HLT);

   // Next-state and control outputs; reset forces a safe, frozen pipeline.
   always_comb begin
      state_d      = state_q;
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      halted       = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      case (state_q)
         RUN: begin
            if (EX_BranchTaken) begin
               IF_ID_Flush  = 1'b1;
               ID_EX_Bubble = 1'b1;
               flush_inc    = 1'b1;
               state_d      = RUN;
            end else if (load_use) begin
               PCWrite      = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Bubble = 1'b1;
               stall_inc    = 1'b1;
               state_d      = STALL;
            end else if (is_hlt) begin
               // Freeze fetch but let the HLT itself advance into EX.
               PCWrite     = 1'b0;
               IF_ID_Write = 1'b0;
               state_d     = HALT;
            end
         end
         STALL: begin
            // The load has moved on; load_use is stale here, so ignore it.
            state_d = RUN;
            if (EX_BranchTaken) begin
               IF_ID_Flush  = 1'b1;
               ID_EX_Bubble = 1'b1;
               flush_inc    = 1'b1;
            end else if (is_hlt) begin
               PCWrite     = 1'b0;
               IF_ID_Write = 1'b0;
               state_d     = HALT;
            end
         end
         HALT: begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            halted       = 1'b1;
            state_d      = HALT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      if (!rst_n) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b0;
         ID_EX_Bubble = 1'b1;
         halted       = 1'b0;
         stall_inc    = 1'b0;
         flush_inc    = 1'b0;
      end
   end

   // Saturating event counters; they hold at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // State and counter registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use stalls, register-0 and unused-source
// cases, branch priority, HLT behaviour, asynchronous reset and counter
// saturation on a narrow-counter instance.
module tb_hazard_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       rst_sat_n;
   logic       mem_read;
   logic [3:0] rd, rs, rt, opcode;
   logic       uses_rs, uses_rt, br_taken;

   logic        pc_write, ifid_write, ifid_flush, idex_bubble, halted;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  state_dbg;

   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_halted;
   logic [1:0]  s_stall_cnt, s_flush_cnt;
   logic [1:0]  s_state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   hazard_ctrl #(.CNT_W(16)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ID_EX_MemRead    (mem_read),
      .ID_EX_RegisterRd (rd),
      .IF_ID_RegisterRs (rs),
      .IF_ID_RegisterRt (rt),
      .IF_ID_UsesRs     (uses_rs),
      .IF_ID_UsesRt     (uses_rt),
      .IF_ID_Opcode     (opcode),
      .EX_BranchTaken   (br_taken),
      .PCWrite          (pc_write),
      .IF_ID_Write      (ifid_write),
      .IF_ID_Flush      (ifid_flush),
      .ID_EX_Bubble     (idex_bubble),
      .halted           (halted),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt),
      .state_dbg_o      (state_dbg)
   );

   hazard_ctrl #(.CNT_W(2)) u_sat (
      .clk              (clk),
      .rst_n            (rst_sat_n),
      .ID_EX_MemRead    (mem_read),
      .ID_EX_RegisterRd (rd),
      .IF_ID_RegisterRs (rs),
      .IF_ID_RegisterRt (rt),
      .IF_ID_UsesRs     (uses_rs),
      .IF_ID_UsesRt     (uses_rt),
      .IF_ID_Opcode     (opcode),
      .EX_BranchTaken   (br_taken),
      .PCWrite          (s_pc_write),
      .IF_ID_Write      (s_ifid_write),
      .IF_ID_Flush      (s_ifid_flush),
      .ID_EX_Bubble     (s_idex_bubble),
      .halted           (s_halted),
      .stall_cnt        (s_stall_cnt),
      .flush_cnt        (s_flush_cnt),
      .state_dbg_o      (s_state_dbg)
   );

   // ---------------- driver tasks ----------------
   task automatic drive(input logic mr, input logic [3:0] d, input logic [3:0] s,
                        input logic [3:0] t, input logic urs, input logic urt,
                        input logic [3:0] op, input logic br);
      mem_read = mr;
      rd       = d;
      rs       = s;
      rt       = t;
      uses_rs  = urs;
      uses_rt  = urt;
      opcode   = op;
      br_taken = br;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'h0, 1'b0);
   endtask

   // Advance one clock; sample point lands 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic pc, input logic ifid,
                          input logic fl, input logic bub, input logic hlt);
      chk({tag, ".PCWrite"},      pc_write,    pc);
      chk({tag, ".IF_ID_Write"},  ifid_write,  ifid);
      chk({tag, ".IF_ID_Flush"},  ifid_flush,  fl);
      chk({tag, ".ID_EX_Bubble"}, idex_bubble, bub);
      chk({tag, ".halted"},       halted,      hlt);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n     = 1'b0;
      rst_sat_n = 1'b0;
      idle();

      // Reset state
      #3;
      chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("reset.stall_cnt", stall_cnt, 0);
      chk("reset.flush_cnt", flush_cnt, 0);
      chk("reset.state", state_dbg, ST_RUN);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Idle RUN
      idle();
      chk_ctl("run_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();

      // Load-use on Rs: stall then one STALL cycle with identical inputs
      drive(1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 4'h0, 1'b0);
      chk_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk("lu_rs.state", state_dbg, ST_STALL);
      chk("lu_rs.stall_cnt", stall_cnt, 1);
      chk_ctl("lu_rs_stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("lu_rs_stall.state", state_dbg, ST_RUN);
      chk("lu_rs_stall.stall_cnt", stall_cnt, 1);

      // Register 0 never hazards
      drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'h0, 1'b0);
      chk_ctl("r0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();

      // Matching Rt but not read: no hazard
      drive(1'b1, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0, 4'h0, 1'b0);
      chk_ctl("rt_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("rt_unused.stall_cnt", stall_cnt, 1);

      // Matching Rt that is read: hazard
      drive(1'b1, 4'd5, 4'd0, 4'd5, 1'b0, 1'b1, 4'h0, 1'b0);
      chk_ctl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk("lu_rt.stall_cnt", stall_cnt, 2);
      idle();
      chk_ctl("lu_rt_stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();

      // Branch outranks load-use
      drive(1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 4'h0, 1'b1);
      chk_ctl("br_lu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      chk("br_lu.stall_cnt", stall_cnt, 2);
      chk("br_lu.flush_cnt", flush_cnt, 1);
      chk("br_lu.state", state_dbg, ST_RUN);

      // Asynchronous reset while in STALL
      drive(1'b1, 4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 4'h0, 1'b0);
      step();
      chk("pre_arst.state", state_dbg, ST_STALL);
      chk("pre_arst.stall_cnt", stall_cnt, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_ctl("arst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("arst.state", state_dbg, ST_RUN);
      chk("arst.stall_cnt", stall_cnt, 0);
      chk("arst.flush_cnt", flush_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      chk_ctl("arst_release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();

      // Branch coincident with HLT: HLT flushed, no halt
      drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'hF, 1'b1);
      chk_ctl("br_hlt", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      chk("br_hlt.state", state_dbg, ST_RUN);
      chk("br_hlt.flush_cnt", flush_cnt, 1);

      // HLT: freeze fetch this cycle, then halted forever
      drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'hF, 1'b0);
      chk_ctl("hlt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 4'h0, 1'b1);
      chk_ctl("halt1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      chk_ctl("halt2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("halt2.state", state_dbg, ST_HALT);
      chk("halt2.flush_cnt", flush_cnt, 1);
      chk("halt2.stall_cnt", stall_cnt, 0);

      // Reset pulse leaves HALT
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      idle();
      chk_ctl("halt_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("halt_rst.flush_cnt", flush_cnt, 0);
      chk("halt_rst.stall_cnt", stall_cnt, 0);
      step();

      // HLT arriving during a STALL cycle
      drive(1'b1, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 4'h0, 1'b0);
      step();
      drive(1'b1, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 4'hF, 1'b0);
      chk_ctl("stall_hlt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("stall_hlt.state", state_dbg, ST_HALT);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      rst_sat_n = 1'b1;
      idle();
      step();

      // Saturation: five branches on both instances
      for (int i = 1; i <= 5; i++) begin
         drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'h0, 1'b1);
         step();
         chk($sformatf("sat.flush_cnt[%0d]", i), s_flush_cnt, (i > 3) ? 3 : i);
         chk($sformatf("wide.flush_cnt[%0d]", i), flush_cnt, i);
      end
      chk("sat.state", s_state_dbg, ST_RUN);
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of stall_cnt and flush_cnt.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-005 ID_EX_RegisterRd  input  4  destination register of the instruction in EX.
REQ-006 IF_ID_RegisterRs  input  4  first source register of the instruction in ID.
REQ-007 IF_ID_RegisterRt  input  4  second source register of the instruction in ID.
REQ-008 IF_ID_UsesRs, IF_ID_UsesRt  input  1 each  the instruction in ID actually reads Rs / Rt.
REQ-009 IF_ID_Opcode  input  4  opcode of the instruction in ID; 4'hF = HLT.
REQ-010 EX_BranchTaken  input  1  branch or jump resolved taken in EX this cycle.
REQ-011 PCWrite  output  1  PC update enable.
REQ-012 IF_ID_Write  output  1  IF/ID latch enable.
REQ-013 IF_ID_Flush  output  1  zero the IF/ID latch at the next edge.
REQ-014 ID_EX_Bubble  output  1  load a NOP into ID/EX at the next edge.
REQ-015 halted  output  1  processor is in the halt state.
REQ-016 stall_cnt  output  CNT_W  number of load-use stalls inserted.
REQ-017 flush_cnt  output  CNT_W  number of taken-branch flushes.

Function
REQ-018 load_use = ID_EX_MemRead & (ID_EX_RegisterRd != 0) & ((IF_ID_UsesRs & Rs==Rd) | (IF_ID_UsesRt & Rt==Rd)); register 0 never causes a hazard.
REQ-019 FSM states: RUN, STALL, HALT; the outputs are a combinational function of the current state and inputs in the same cycle.
REQ-020 RUN with no event: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, halted=0; stay in RUN.
REQ-021 Priority in RUN and STALL: EX_BranchTaken, then load_use, then HLT.
REQ-022 EX_BranchTaken in RUN or STALL: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, IF_ID_Write=1; next state RUN; flush_cnt increments.
REQ-023 load_use in RUN without a branch: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next state STALL; stall_cnt increments.
REQ-024 STALL: load_use is ignored, so at most one bubble is inserted per load; outputs as in REQ-020 unless a branch is taken; next state RUN.
REQ-025 IF_ID_Opcode==4'hF in RUN or STALL without a branch or load_use: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=0, so the HLT proceeds to EX; next state HALT.
REQ-026 HALT: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1, halted=1; all inputs ignored; leave only via reset.
REQ-027 A taken branch coincident with HLT in ID flushes the HLT; no transition to HALT.
REQ-028 Counters saturate at all-ones and do not wrap; they do not count in HALT.

Reset
REQ-029 rst_n=0 forces the state to RUN and both counters to 0 immediately, independent of clk.
REQ-030 While rst_n=0: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1, halted=0.
REQ-031 Reset asserted mid-STALL or in HALT returns to RUN; normal RUN outputs apply from the first cycle after release.

Verification
REQ-032 Load-use: MemRead=1, Rd=3, Rs=3, UsesRs=1 -> that cycle PCWrite=0, IF_ID_Write=0, Bubble=1; next cycle in STALL with the same inputs gives PCWrite=1, Bubble=0; stall_cnt=1.
REQ-033 Register 0 and unused source: Rd=0, Rs=0 -> no stall; Rd=5, Rt=5, UsesRt=0 -> no stall.
REQ-034 Branch over load-use: EX_BranchTaken=1 with load_use=1 -> Flush=1, Bubble=1, PCWrite=1; stall_cnt unchanged; flush_cnt=1.
REQ-035 Halt: Opcode=4'hF -> PCWrite=0 that cycle; halted=1 on every later cycle even with EX_BranchTaken=1; after rst_n pulse, halted=0 and counters are 0.
REQ-036 Saturation with CNT_W=2: five taken branches -> flush_cnt = 3.
REQ-037 Asynchronous reset: drop rst_n between clock edges while in STALL -> outputs take the REQ-030 values before the next edge.
